// File: rtl/eq_coef_pkg.sv
// Shared definitions for the EQ coefficient loader: control-word field layout,
// default coefficient and the loader FSM state encoding.
package eq_coef_pkg;

    localparam int CTL_COMMIT_BIT = 31;
    localparam int CTL_CLEAR_BIT  = 30;
    localparam int CTL_ADDR_LSB   = 16;
    localparam int CTL_DATA_MSB   = 15;

    // Unity gain in the coefficient RAM's fixed-point format.
    localparam logic [15:0] EQ_DEFAULT_COEF = 16'h1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } eq_state_e;

endpackage

// File: rtl/eq_ctl_qual.sv
// Two-stage capture of the software control word. The word is trusted only once
// two consecutive samples agree, which hides skew between bits of a register update.
module eq_ctl_qual (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] ctl_in,
    output logic [31:0] ctl_q,
    output logic        stable
);

    logic [31:0] q1;
    logic [31:0] q2;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            q1 <= ctl_in;
            q2 <= q1;
        end
    end

    assign ctl_q  = q2;
    assign stable = (q2 == q1);

endmodule

// File: rtl/eq_coef_loader.sv
// Decodes the eq0 control word into single-coefficient writes (commit toggle)
// and full-table clear sweeps on one coefficient RAM write port.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for a stable clear edge or a pending commit toggle
//   ST_WRITE | one-cycle single-coefficient write, bumps write_cnt
//   ST_CLEAR | sweeping every address with the default coefficient
module eq_coef_loader
    import eq_coef_pkg::*;
#(
    parameter int          ADDR_W       = 10,
    parameter logic [15:0] DEFAULT_COEF = EQ_DEFAULT_COEF
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctl_in,
    output logic              coef_we,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [15:0]       coef_data,
    output logic              busy,
    output logic [15:0]       write_cnt
);

    logic [31:0] q_word;
    logic        q_stable;

    eq_ctl_qual u_qual (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctl_in     (ctl_in),
        .ctl_q      (q_word),
        .stable     (q_stable)
    );

    if (ADDR_W < 14) begin : g_addr_pad
        logic unused_addr_bits;
        assign unused_addr_bits = ^q_word[29:CTL_ADDR_LSB+ADDR_W];
    end

    eq_state_e         state, state_nxt;
    logic              last_toggle, last_toggle_nxt;
    logic              clr_prev, clr_prev_nxt;
    logic              coef_we_nxt;
    logic [ADDR_W-1:0] coef_addr_nxt;
    logic [15:0]       coef_data_nxt;
    logic              busy_nxt;
    logic [15:0]       write_cnt_nxt;
    logic              commit_pend;
    logic              clr_edge;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state       <= ST_IDLE;
            last_toggle <= 1'b0;
            clr_prev    <= 1'b0;
            coef_we     <= 1'b0;
            coef_addr   <= '0;
            coef_data   <= '0;
            busy        <= 1'b0;
            write_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            last_toggle <= last_toggle_nxt;
            clr_prev    <= clr_prev_nxt;
            coef_we     <= coef_we_nxt;
            coef_addr   <= coef_addr_nxt;
            coef_data   <= coef_data_nxt;
            busy        <= busy_nxt;
            write_cnt   <= write_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        last_toggle_nxt = last_toggle;
        clr_prev_nxt    = clr_prev;
        coef_we_nxt     = 1'b0;
        coef_addr_nxt   = coef_addr;
        coef_data_nxt   = coef_data;
        busy_nxt        = 1'b0;
        write_cnt_nxt   = write_cnt;

        commit_pend = q_stable && (q_word[CTL_COMMIT_BIT] != last_toggle);
        clr_edge    = q_stable && q_word[CTL_CLEAR_BIT] && !clr_prev;

        // Clear edge detection keeps tracking during a sweep so a held bit never retriggers.
        if (q_stable) begin
            clr_prev_nxt = q_word[CTL_CLEAR_BIT];
        end

        case (state)
            ST_IDLE: begin
                if (clr_edge) begin
                    state_nxt     = ST_CLEAR;
                    coef_we_nxt   = 1'b1;
                    coef_addr_nxt = '0;
                    coef_data_nxt = DEFAULT_COEF;
                    busy_nxt      = 1'b1;
                end else if (commit_pend) begin
                    state_nxt       = ST_WRITE;
                    coef_we_nxt     = 1'b1;
                    coef_addr_nxt   = q_word[CTL_ADDR_LSB +: ADDR_W];
                    coef_data_nxt   = q_word[CTL_DATA_MSB:0];
                    last_toggle_nxt = q_word[CTL_COMMIT_BIT];
                end
            end
            ST_WRITE: begin
                write_cnt_nxt = write_cnt + 16'd1;
                state_nxt     = ST_IDLE;
            end
            ST_CLEAR: begin
                if (&coef_addr) begin
                    state_nxt = ST_IDLE;
                end else begin
                    coef_we_nxt   = 1'b1;
                    coef_addr_nxt = coef_addr + ADDR_W'(1);
                    coef_data_nxt = DEFAULT_COEF;
                    busy_nxt      = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_eq_coef_loader.sv
// Directed and randomized checks of eq_coef_loader (ADDR_W=4) against an
// event-level model of the control-word rules.
module tb_eq_coef_loader;

    localparam int AW = 4;

    logic          user_clk   = 1'b0;
    logic          user_rst_n = 1'b0;
    logic [31:0]   ctl_in     = '0;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [15:0]   coef_data;
    logic          busy;
    logic [15:0]   write_cnt;

    eq_coef_loader #(.ADDR_W(AW), .DEFAULT_COEF(16'h1000)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctl_in     (ctl_in),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .busy       (busy),
        .write_cnt  (write_cnt)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic          busy;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            cyc;
    } wr_t;

    wr_t wlog[$];
    wr_t wexp[$];
    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;

    always @(negedge user_clk) begin
        wr_t e;
        cyc++;
        if (user_rst_n && coef_we) begin
            e.busy = busy;
            e.addr = coef_addr;
            e.data = coef_data;
            e.cyc  = cyc;
            wlog.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    task automatic chk_sweep(input string tag, input int base);
        for (int i = 0; i < 16; i++) begin
            if (base + i < wlog.size()) begin
                chk($sformatf("%s_busy%0d", tag, i), 32'(wlog[base+i].busy), 32'd1);
                chk($sformatf("%s_addr%0d", tag, i), 32'(wlog[base+i].addr), 32'(i));
                chk($sformatf("%s_data%0d", tag, i), 32'(wlog[base+i].data), 32'h1000);
                if (i > 0)
                    chk($sformatf("%s_gap%0d", tag, i),
                        32'(wlog[base+i].cyc - wlog[base+i-1].cyc), 32'd1);
            end
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_we"},   32'(coef_we),   32'd0);
        chk({tag, "_addr"}, 32'(coef_addr), 32'd0);
        chk({tag, "_data"}, 32'(coef_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy),      32'd0);
        chk({tag, "_cnt"},  32'(write_cnt), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic        m_toggle;
        logic        m_clr;
        logic [15:0] m_cnt;
        int          hold;
        int          n_busy;
        wr_t         e;

        // Reset state
        tick(2);
        chk_zero_outputs("reset");
        user_rst_n = 1'b1;
        tick(3);

        // Single commit with latency check
        wlog.delete();
        ctl_in = 32'h8005_1234;
        tick(2);
        chk("commit_early_we", 32'(coef_we), 32'd0);
        tick(1);
        chk("commit_we", 32'(coef_we), 32'd1);
        chk("commit_addr", 32'(coef_addr), 32'd5);
        chk("commit_data", 32'(coef_data), 32'h1234);
        tick(1);
        chk("commit_we_drop", 32'(coef_we), 32'd0);
        chk("commit_cnt", 32'(write_cnt), 32'd1);
        tick(4);
        chk("commit_pulses", 32'(wlog.size()), 32'd1);

        // Toggle back, then re-present the same word
        wlog.delete();
        ctl_in = 32'h0006_ABCD;
        tick(6);
        chk("toggle_pulses", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            chk("toggle_addr", 32'(wlog[0].addr), 32'd6);
            chk("toggle_data", 32'(wlog[0].data), 32'hABCD);
        end
        chk("toggle_cnt", 32'(write_cnt), 32'd2);
        wlog.delete();
        ctl_in = 32'h0006_ABCD;
        tick(6);
        chk("repeat_pulses", 32'(wlog.size()), 32'd0);

        // Clear sweep, then hold the clear bit
        wlog.delete();
        ctl_in = 32'h4000_0000;
        tick(2);
        chk("clear_early_busy", 32'(busy), 32'd0);
        tick(1);
        chk("clear_busy", 32'(busy), 32'd1);
        chk("clear_we", 32'(coef_we), 32'd1);
        tick(16);
        chk("clear_busy_drop", 32'(busy), 32'd0);
        chk("clear_we_drop", 32'(coef_we), 32'd0);
        tick(30);
        chk("clear_writes", 32'(wlog.size()), 32'd16);
        chk_sweep("clear", 0);
        chk("clear_cnt", 32'(write_cnt), 32'd2);

        // Commit toggled mid-sweep is serviced after the sweep
        ctl_in = 32'h0000_0000;
        tick(4);
        wlog.delete();
        ctl_in = 32'h4000_0000;
        tick(7);
        ctl_in = 32'hC003_0042;
        tick(30);
        chk("midclr_writes", 32'(wlog.size()), 32'd17);
        chk_sweep("midclr", 0);
        if (wlog.size() > 16) begin
            chk("midclr_wr_busy", 32'(wlog[16].busy), 32'd0);
            chk("midclr_wr_addr", 32'(wlog[16].addr), 32'd3);
            chk("midclr_wr_data", 32'(wlog[16].data), 32'h0042);
            chk("midclr_wr_gap", 32'(wlog[16].cyc - wlog[15].cyc), 32'd2);
        end
        chk("midclr_cnt", 32'(write_cnt), 32'd3);

        // Two toggles mid-sweep cancel out
        ctl_in = 32'h8000_0000;
        tick(4);
        wlog.delete();
        ctl_in = 32'hC000_0000;
        tick(5);
        ctl_in = 32'h4000_0077;
        tick(3);
        ctl_in = 32'hC000_0077;
        tick(25);
        chk("dbl_writes", 32'(wlog.size()), 32'd16);
        n_busy = 0;
        foreach (wlog[i]) if (wlog[i].busy) n_busy++;
        chk("dbl_sweep_writes", 32'(n_busy), 32'd16);
        chk("dbl_cnt", 32'(write_cnt), 32'd3);

        // Unstable input: alternate words every cycle
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            ctl_in = (i % 2 == 0) ? 32'h0009_5555 : 32'h800A_6666;
            tick(1);
            chk($sformatf("unstable_we%0d", i), 32'(coef_we), 32'd0);
            chk($sformatf("unstable_busy%0d", i), 32'(busy), 32'd0);
        end
        ctl_in = 32'h0009_5555;
        tick(2);
        chk("settle_early_we", 32'(coef_we), 32'd0);
        tick(1);
        chk("settle_we", 32'(coef_we), 32'd1);
        chk("settle_addr", 32'(coef_addr), 32'd9);
        chk("settle_data", 32'(coef_data), 32'h5555);
        tick(3);
        chk("settle_pulses", 32'(wlog.size()), 32'd1);
        chk("settle_cnt", 32'(write_cnt), 32'd4);

        // Reset in the middle of a sweep
        ctl_in = 32'h4000_0000;
        tick(3);
        chk("rstsweep_start", 32'(busy), 32'd1);
        tick(7);
        chk("rstsweep_addr7", 32'(coef_addr), 32'd7);
        ctl_in = 32'h0000_0000;
        #2;
        user_rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst_async");
        tick(2);
        wlog.delete();
        user_rst_n = 1'b1;
        tick(20);
        chk("rst_after_writes", 32'(wlog.size()), 32'd0);
        chk("rst_after_busy", 32'(busy), 32'd0);
        chk("rst_after_cnt", 32'(write_cnt), 32'd0);

        // Randomized words against the event-level model
        wlog.delete();
        wexp.delete();
        m_toggle = 1'b0;
        m_clr    = 1'b0;
        m_cnt    = '0;
        for (int k = 0; k < 40; k++) begin
            w     = $urandom;
            w[30] = ($urandom_range(0, 5) == 0);
            hold  = 3 + $urandom_range(0, 3);
            if (w[30] && !m_clr) begin
                for (int a = 0; a < 16; a++) begin
                    e.busy = 1'b1;
                    e.addr = AW'(a);
                    e.data = 16'h1000;
                    e.cyc  = 0;
                    wexp.push_back(e);
                end
                hold = 24;
            end
            m_clr = w[30];
            if (w[31] != m_toggle) begin
                e.busy = 1'b0;
                e.addr = w[16 +: AW];
                e.data = w[15:0];
                e.cyc  = 0;
                wexp.push_back(e);
                m_toggle = w[31];
                m_cnt++;
            end
            ctl_in = w;
            tick(hold);
        end
        tick(30);
        chk("rand_writes", 32'(wlog.size()), 32'(wexp.size()));
        for (int i = 0; i < wexp.size(); i++) begin
            if (i < wlog.size()) begin
                chk($sformatf("rand_busy%0d", i), 32'(wlog[i].busy), 32'(wexp[i].busy));
                chk($sformatf("rand_addr%0d", i), 32'(wlog[i].addr), 32'(wexp[i].addr));
                chk($sformatf("rand_data%0d", i), 32'(wlog[i].data), 32'(wexp[i].data));
            end
        end
        chk("rand_cnt", 32'(write_cnt), 32'(m_cnt));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eq_coef_loader.md
Name: eq_coef_loader

Overview:
Downstream consumer of the eq0 control software register (the 32-bit user_data_out word written by the PPC over OPB). It decodes the control word into writes to one EQ coefficient BRAM port. A single-coefficient write is triggered by toggling the commit bit. A full-table clear sweeps every address with a default value. The block runs entirely in the user_clk (DSP fabric) domain, between the control register and the per-input coefficient RAM.

Parameters:
ADDR_W, 10, coefficient RAM address width; legal range 1..14 (field ctl_in[16+ADDR_W-1:16])
DEFAULT_COEF, 16'h1000, value written to every address during a clear sweep (unity gain)

Ports:
user_clk  input  1  fabric clock; all logic is rising-edge
user_rst_n  input  1  asynchronous active-low reset
ctl_in  input  32  control word from the software register: [31] commit toggle, [30] clear request, [29:16] address (low ADDR_W bits used), [15:0] coefficient
coef_we  output  1  coefficient RAM write enable, one-cycle pulses
coef_addr  output  ADDR_W  coefficient RAM write address
coef_data  output  16  coefficient RAM write data
busy  output  1  high while a clear sweep is in progress
write_cnt  output  16  count of completed single-coefficient writes; wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async assert, sync release) clears these to 0:
  - all outputs
  - input stages q1 and q2
  - last_toggle and clr_prev
  - FSM state returns to IDLE
- Input qualification:
  - ctl_in is registered into q1, then q1 into q2, every cycle.
  - A word is "stable" when q2 == q1 (all 32 bits). Decisions use q2 only, and only while stable. This filters multi-bit update skew from the register.
- Events, evaluated on stable q2:
  - commit_pend = q2[31] != last_toggle
  - clr_edge = q2[30] & ~clr_prev
  - clr_prev updates to q2[30] on every stable cycle.
- FSM states: IDLE, WRITE, CLEAR.
- IDLE:
  - If clr_edge: go to CLEAR with the address counter at 0. Clear takes priority when it coincides with a pending commit.
  - Else if commit_pend: go to WRITE, latching coef_addr = q2[16+ADDR_W-1:16], coef_data = q2[15:0], last_toggle = q2[31].
- WRITE:
  - coef_we is high for exactly one cycle, write_cnt increments, then return to IDLE.
  - Latency: coef_we is first high in the cycle after the 3rd rising edge following presentation of the new ctl_in.
  - Back-to-back commits need a fresh toggle. Minimum spacing is one IDLE cycle.
- CLEAR:
  - coef_we = 1, coef_data = DEFAULT_COEF, busy = 1.
  - coef_addr steps 0, 1, …, 2^ADDR_W-1, one per cycle, for exactly 2^ADDR_W cycles.
  - On the last address, return to IDLE. busy and coef_we drop the next cycle.
  - write_cnt does not count sweep writes.
- Outside WRITE and CLEAR: coef_we = 0, and coef_addr/coef_data hold their last values.
- Clear while held: a clear bit held high does not retrigger. Software must drop then raise it.
- Commit toggled during CLEAR: stays pending via the last_toggle compare and is serviced immediately after the sweep. The serviced value is the q2 contents at that time.
- An even number of toggles while busy cancels out; no write occurs. This is by design.
- Reset mid-sweep or mid-write aborts immediately. No write completes, and there is no resume.
- Unused address bits q2[29:16+ADDR_W] are ignored.
- All outputs are registered.

Decomposition:
- Shared package eq_coef_pkg holds:
  - control-word field positions (CTL_COMMIT_BIT=31, CTL_CLEAR_BIT=30, CTL_ADDR_LSB=16, CTL_DATA_MSB=15)
  - the FSM state enum
  - the default DEFAULT_COEF constant
- One sub-module, eq_ctl_qual: the two-stage input register plus stability compare. Outputs are the qualified word and a stable flag.
- The FSM, counters and output registers live in eq_coef_loader.

Test Plan:
- Single commit: ctl_in 0x0000_0000 -> 0x8005_1234. Exactly one coef_we pulse, 3 edges later, with coef_addr=5, coef_data=0x1234. write_cnt=1.
- Toggle back: then 0x0006_ABCD (bit31 back to 0). One pulse with addr=6, data=0xABCD, write_cnt=2. Re-presenting the same word gives no pulse.
- Clear sweep (ADDR_W=4): set bit30. busy high for 16 cycles, coef_we high for all 16, addresses 0..15 in order, data 0x1000. Holding bit30 high causes no second sweep.
- Commit during clear: toggle bit31 with addr=3, data=0x0042 mid-sweep. The sweep completes uninterrupted, then one write of addr 3 / 0x0042 follows. Toggling twice mid-sweep produces no write.
- Unstable input: change ctl_in on alternating cycles for 10 cycles. coef_we stays 0 and no state change occurs until the word holds for 2 cycles.
- Reset mid-sweep: assert user_rst_n=0 at sweep address 7. All outputs drop to 0 asynchronously. After release, with ctl_in static, no write and no sweep occur until a new edge or toggle.
